// File: rtl/time_disp_pkg.sv
// Shared constants for the stopwatch display scanner: segment patterns (active-high),
// slot indices and the blank/drive state type.
package time_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_DASH = 7'h01;

    localparam logic [2:0] IDX_HUND  = 3'd0;
    localparam logic [2:0] IDX_TENTH = 3'd1;
    localparam logic [2:0] IDX_SLSB  = 3'd2;
    localparam logic [2:0] IDX_SMSB  = 3'd3;
    localparam logic [2:0] IDX_MIN   = 3'd4;

    typedef logic [4:0][3:0] digits_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/time_disp_scan_bcd_to_seg.sv
// BCD digit to active-high 7-segment pattern (seg[6]=a .. seg[0]=g); non-BCD shows a dash.
module bcd_to_seg
    import time_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_disp_scan.sv
// Five-digit multiplexed 7-segment scanner for the stopwatch: per-frame snapshot with
// lap hold, anti-ghost blanking at the start of each slot, registered pin outputs.
module time_disp_scan
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    input  logic       blank_lz,
    input  logic [3:0] hundredths,
    input  logic [3:0] tenths,
    input  logic [3:0] sec_lsb,
    input  logic [3:0] sec_msb,
    input  logic [3:0] minutes,
    output logic [6:0] seg,
    output logic       dp,
    output logic [4:0] an,
    output logic       frame_done
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    scan_state_t   state_q, state_d;
    digits_t       snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [4:0]    an_q, an_d;

    logic          wrap;
    logic [3:0]    digit;
    logic [6:0]    seg_pat;
    logic [6:0]    seg_on;
    logic [4:0]    an_on;
    logic          dp_on;

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (digit),
        .seg_o (seg_pat)
    );

    assign digit = snap_q[idx_q];

    always_comb begin
        wrap       = (presc_q == PW'(SCAN_DIV - 1));
        frame_done = wrap && (idx_q == IDX_MIN);
        presc_d    = wrap ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_MIN) ? IDX_HUND : idx_q + 3'd1;
        end

        // Blank check is second so that BLANK_CYCLES=0 still yields a driven slot.
        state_d = state_q;
        if (presc_d == PW'(BLANK_CYCLES)) begin
            state_d = DRIVE;
        end else if (presc_d == '0) begin
            state_d = BLANK;
        end

        snap_d = snap_q;
        if (frame_done && !hold) begin
            snap_d = {minutes, sec_msb, sec_lsb, tenths, hundredths};
        end

        an_on  = '0;
        seg_on = '0;
        dp_on  = 1'b0;
        if (state_q == DRIVE) begin
            an_on  = 5'b00001 << idx_q;
            seg_on = (idx_q == IDX_MIN && blank_lz && digit == 4'd0) ? 7'h00 : seg_pat;
            dp_on  = (idx_q == IDX_SLSB) || (idx_q == IDX_MIN);
        end

        an_d  = AN_ACT_LOW  ? ~an_on  : an_on;
        seg_d = SEG_ACT_LOW ? ~seg_on : seg_on;
        dp_d  = SEG_ACT_LOW ? ~dp_on  : dp_on;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q <= '0;
            idx_q   <= IDX_HUND;
            state_q <= BLANK;
            snap_q  <= '0;
            an_q    <= AN_ACT_LOW  ? 5'h1F : 5'h00;
            seg_q   <= SEG_ACT_LOW ? 7'h7F : 7'h00;
            dp_q    <= SEG_ACT_LOW;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_time_disp_scan.sv
// Bench for time_disp_scan: directed scenarios plus random digits, checked every clock
// against a frame/slot arithmetic model of the display.
module tb_time_disp_scan;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 5 * SD;

    localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic       clk = 1'b0;
    logic       clr;
    logic       hold;
    logic       blank_lz;
    logic [3:0] dig [5];
    logic [6:0] seg;
    logic       dp;
    logic [4:0] an;
    logic       frame_done;

    int         checks = 0;
    int         errors = 0;
    int         k;
    int         msnap [5];

    time_disp_scan #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .hold       (hold),
        .blank_lz   (blank_lz),
        .hundredths (dig[0]),
        .tenths     (dig[1]),
        .sec_lsb    (dig[2]),
        .sec_msb    (dig[3]),
        .minutes    (dig[4]),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // One clock: outputs after the edge reflect what the display should show during cycle k.
    task automatic tick();
        int         slot;
        int         ph;
        int         d;
        logic [4:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [6:0] p;
        slot = (k / SD) % 5;
        ph   = k % SD;
        chk("frame_done", {7'd0, frame_done}, {7'd0, (k % FRAME) == FRAME - 1});
        e_an  = 5'h1F;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (ph >= BC) begin
            d    = msnap[slot];
            p    = (d <= 9) ? PAT[d] : 7'h01;
            if (slot == 4 && blank_lz && d == 0) p = 7'h00;
            e_an  = ~(5'b00001 << slot);
            e_seg = ~p;
            e_dp  = !(slot == 2 || slot == 4);
        end
        if ((k % FRAME) == FRAME - 1 && !hold) begin
            for (int i = 0; i < 5; i++) msnap[i] = dig[i];
        end
        @(posedge clk);
        #1;
        k++;
        chk("an",  {3'd0, an},  {3'd0, e_an});
        chk("seg", {1'b0, seg}, {1'b0, e_seg});
        chk("dp",  {7'd0, dp},  {7'd0, e_dp});
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int phase);
        while ((k % FRAME) != phase) tick();
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d, input int e);
        dig[0] = 4'(a); dig[1] = 4'(b); dig[2] = 4'(c); dig[3] = 4'(d); dig[4] = 4'(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},  {3'd0, an},  8'h1F);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        chk({tag, "_dp"},  {7'd0, dp},  8'h01);
        chk({tag, "_fd"},  {7'd0, frame_done}, 8'h00);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        k   = 0;
        for (int i = 0; i < 5; i++) msnap[i] = 0;
    endtask

    initial begin
        clr      = 1'b1;
        hold     = 1'b0;
        blank_lz = 1'b0;
        k        = 0;
        set_digits(0, 0, 0, 0, 0);
        #12;
        check_reset_outputs("reset");
        release_reset();

        // Steady scan of 1..5; the first frame still shows the reset snapshot.
        set_digits(1, 2, 3, 4, 5);
        run(2 * FRAME);

        // Reset while a digit is being driven.
        run_to(5);
        clr = 1'b1;
        #1;
        check_reset_outputs("clr_mid_drive");
        release_reset();
        run(2);
        chk("first_anode_pre", {3'd0, an}, 8'h1F);
        run(1);
        chk("first_anode", {3'd0, an}, {3'd0, 5'b11110});
        run(2 * FRAME - 3);

        // Snapshot is frame-aligned: minutes changes during slot 2.
        run_to(2 * SD + 2);
        dig[4] = 4'd7;
        run_to(FRAME - 1);
        run(FRAME + 1);

        // Lap hold across a boundary, released mid-frame.
        run_to(20);
        hold = 1'b1;
        set_digits(9, 9, 9, 5, 9);
        run_to(FRAME - 1);
        run(1);
        run_to(10);
        hold = 1'b0;
        run_to(FRAME - 1);
        run(FRAME + 1);

        // Leading-zero blanking, then dash on a non-BCD minutes digit.
        blank_lz = 1'b1;
        dig[4]   = 4'd0;
        run_to(FRAME - 1);
        run(FRAME);
        run_to(4 * SD + BC + 1);
        chk("lz_seg", {1'b0, seg}, 8'h7F);
        chk("lz_an",  {3'd0, an},  {3'd0, 5'b01111});
        chk("lz_dp",  {7'd0, dp},  8'h00);
        blank_lz = 1'b0;
        dig[4]   = 4'hC;
        run_to(FRAME - 1);
        run(FRAME);
        run_to(4 * SD + BC + 1);
        chk("dash_seg", {1'b0, seg}, {1'b0, 7'b1111110});

        // Random digits, hold and blank_lz.
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 5; i++) dig[i] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 0) dig[4] = 4'd0;
            end
            hold     = ($urandom_range(0, 2) == 0);
            blank_lz = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
